// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus between a program source and imem_loader.
// master: byte source / supervisor side; slave: the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;
  logic              cpu_run;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start, rx_valid, rx_byte,
    input  rx_ready, wea, addra, dina, cpu_run, load_err, words_loaded
  );

  modport slave (
    input  start, rx_valid, rx_byte,
    output rx_ready, wea, addra, dina, cpu_run, load_err, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory, then releases the CPU.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [2:0]        state_q, state_d;
  logic [8:0]        rem_q, rem_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       dina_q, dina_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        cs_q, cs_d;
`endif

  logic rx_ready;
  logic xfer;

  assign rx_ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign xfer     = bus.rx_valid && rx_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    dina_d  = dina_q;
    addr_d  = addr_q;
    words_d = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    cs_d    = cs_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_d = S_COUNT;
          words_d = '0;
          addr_d  = BASE;
          bcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          cs_d    = '0;
`endif
        end
      end
      S_COUNT: begin
        if (xfer) begin
          // A zero length byte encodes a full 256-word image
          rem_d   = (bus.rx_byte == 8'd0) ? 9'd256 : {1'b0, bus.rx_byte};
          bcnt_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          cs_d = cs_q ^ bus.rx_byte;
`endif
          if (bcnt_q == 2'd3) begin
            dina_d  = {asm_q, bus.rx_byte};
            bcnt_d  = '0;
            state_d = S_WRITE;
          end else begin
            asm_d  = {asm_q[15:0], bus.rx_byte};
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 1'b1;
        rem_d   = rem_q - 9'd1;
        if (rem_q != 9'd1) begin
          state_d = S_DATA;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          state_d = (bus.rx_byte == cs_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      dina_q  <= '0;
      addr_q  <= BASE;
      words_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cs_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      dina_q  <= dina_d;
      addr_q  <= addr_d;
      words_q <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cs_q    <= cs_d;
`endif
    end
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.wea          = (state_q == S_WRITE);
  assign bus.addra        = addr_q;
  assign bus.dina         = dina_q;
  assign bus.cpu_run      = (state_q == S_DONE);
  assign bus.words_loaded = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.load_err     = (state_q == S_ERROR);
`else
  assign bus.load_err     = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized bench for imem_loader against a queue-based reference model.
module tb_imem_loader;
  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int AMOD      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  data_q[$];
  logic [39:0] mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Every write pulse must match the next word the model predicts.
  always @(negedge clk) begin
    if (bus.wea !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("extra_wea", 64'(bus.wea), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wea_addr", 64'(bus.addra), 64'(mon_e[39:32]));
        check("wea_data", 64'(bus.dina), 64'(mon_e[31:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rx_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_wea",      64'(bus.wea),          64'd0);
    check("rst_rx_ready", 64'(bus.rx_ready),     64'd0);
    check("rst_cpu_run",  64'(bus.cpu_run),      64'd0);
    check("rst_load_err", 64'(bus.load_err),     64'd0);
    check("rst_addra",    64'(bus.addra),        64'(BASE_ADDR % AMOD));
    check("rst_dina",     64'(bus.dina),         64'd0);
    check("rst_words",    64'(bus.words_loaded), 64'd0);
  endtask

  // Streams data_q as a program of length byte nbyte; all arguments are model-side knobs.
  task automatic run_load(input logic [7:0] nbyte, input int gap_at, input int gap_len,
                          input logic [7:0] cs_mask, input int start_at);
    int nw;
    int n;
    logic [7:0]  cs;
    logic [31:0] w;
    logic [31:0] last_w;
    bit exp_err;
    nw = (nbyte == 8'd0) ? 256 : int'(nbyte);
    cs = 8'd0;
    last_w = 32'd0;
    for (int i = 0; i < nw; i++) begin
      w = {data_q[4*i], data_q[4*i+1], data_q[4*i+2], data_q[4*i+3]};
      exp_q.push_back({8'((BASE_ADDR + i) % AMOD), w});
      last_w = w;
    end
    foreach (data_q[i]) cs ^= data_q[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = (cs_mask != 8'd0);
`else
    exp_err = 1'b0;
`endif

    pulse_start();
    check("start_cpu_run_drop",  64'(bus.cpu_run),  64'd0);
    check("start_load_err_drop", 64'(bus.load_err), 64'd0);
    check("start_count_ready",   64'(bus.rx_ready), 64'd1);
    check("start_words_clear",   64'(bus.words_loaded), 64'd0);

    send_byte(nbyte);
    for (int i = 0; i < 4*nw; i++) begin
      if (i == gap_at) begin
        repeat (gap_len) @(negedge clk);
        if (gap_len >= 2) begin
          check("stall_words", 64'(bus.words_loaded), 64'(i / 4));
          check("stall_addra", 64'(bus.addra), 64'((BASE_ADDR + i / 4) % AMOD));
        end
      end
      if (i == start_at) pulse_start();
      send_byte(data_q[i]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs ^ cs_mask);
`endif
    n = 0;
    while (bus.cpu_run !== 1'b1 && bus.load_err !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("finish_timeout", 64'd0, 64'd1);
    check("end_cpu_run",  64'(bus.cpu_run),  64'(!exp_err));
    check("end_load_err", 64'(bus.load_err), 64'(exp_err));
    check("end_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("end_words",    64'(bus.words_loaded), 64'(nw));
    check("end_addra",    64'(bus.addra), 64'((BASE_ADDR + nw) % AMOD));
    check("end_dina_hold", 64'(bus.dina), 64'(last_w));
    repeat (3) @(negedge clk);
    check("hold_cpu_run", 64'(bus.cpu_run), 64'(!exp_err));
    check("writes_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic load_ref_program();
    logic [7:0] prog [8];
    prog = '{8'h20, 8'hE7, 8'h00, 8'h05, 8'h30, 8'h00, 8'h00, 8'h01};
    data_q.delete();
    foreach (prog[i]) data_q.push_back(prog[i]);
  endtask

  initial begin
    int nw;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(bus.rx_ready), 64'd0);

    // Reference two-word program
    load_ref_program();
    run_load(8'h02, -1, 0, 8'h00, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum (0x00 sent instead of 0xF3)
    load_ref_program();
    run_load(8'h02, -1, 0, 8'hF3, -1);
`endif

    // Ten-cycle rx_valid gap between bytes 2 and 3
    data_q.delete();
    data_q.push_back(8'h11); data_q.push_back(8'h22);
    data_q.push_back(8'h33); data_q.push_back(8'h44);
    run_load(8'h01, 2, 10, 8'h00, -1);

    // Randomized programs with random gaps, stray starts and checksum faults
    for (int t = 0; t < 8; t++) begin
      nw = int'($urandom_range(1, 12));
      data_q.delete();
      for (int i = 0; i < 4*nw; i++) data_q.push_back(8'($urandom));
      run_load(8'(nw), int'($urandom_range(0, 4*nw-1)), int'($urandom_range(0, 5)),
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
               ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4*nw-1)) : -1);
    end

    // Full 256-word image, address wraps to BASE
    data_q.delete();
    for (int i = 0; i < 1024; i++) data_q.push_back(8'($urandom));
    run_load(8'h00, 517, 3, 8'h00, -1);

    // Reset in the middle of a word
    pulse_start();
    send_byte(8'h03);
    send_byte(8'hAB);
    send_byte(8'hCD);
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    load_ref_program();
    run_load(8'h02, -1, 0, 8'h00, -1);

    // Start pulsed during DATA is ignored
    data_q.delete();
    for (int i = 0; i < 12; i++) data_q.push_back(8'($urandom));
    run_load(8'h03, -1, 0, 8'h00, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
